lipsi_mem_arbiter: RTL and testbench
====================================

# lipsi_mem_arbiter

Arbiter sharing the single-port 256x8 Lipsi data memory between the Lipsi core and a host loader/debug port. Each requester uses a req/ack handshake. The arbiter serialises accesses through a three-state FSM, applies round-robin fairness, and provides a host lock that excludes the core. It sits between lipsi_processor's data-memory path and a synchronous single-port RAM with 1-cycle read latency.

## Interface
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width
- clk  in  1  rising-edge clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  DW  read data, valid only while core_ack=1
- host_req, host_we, host_addr, host_wdata, host_ack, host_rdata  same as core_*, for the host
- host_lock  in  1  while 1, the core is never granted
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en
- busy  out  1  FSM not in IDLE
- owner  out  1  0 = core, 1 = host; current or last grant

## Operation
- FSM states:
  - IDLE: samples requests; no winner stays IDLE; a winner goes to ACCESS.
  - ACCESS: drives mem_* for exactly one cycle, then RESP.
  - RESP: pulses the winner's ack, then IDLE unconditionally.
- Eligibility: core eligible = core_req & ~host_lock; host eligible = host_req.
- Winner selection in IDLE:
  - Only one eligible requester: it wins.
  - Both eligible: the requester not equal to last_grant wins.
  - last_grant updates on entry to ACCESS.
- Sampling: request fields are captured into internal registers at the IDLE->ACCESS edge. Requester inputs are ignored in ACCESS and RESP.
- Write access: mem_we=1 and mem_wdata=captured data; ack pulses in RESP; rdata is 0.
- Read access: mem_we=0; ack pulses in RESP; rdata = mem_rdata.
- Non-winner rdata stays 0. Ack never pulses to both requesters in the same cycle.
- req dropped after capture: the access still completes, including the write commit, and ack still pulses. The requester ignores it.
- host_lock rising during ACCESS or RESP: an in-flight core access completes normally. Lock takes effect at the next IDLE.
- owner holds the last granted requester. busy = (state != IDLE).

## Timing
- Reset (reset_n=0, asynchronous):
  - state=IDLE, last_grant=host (so the first tie goes to the core), owner=1.
  - All acks, rdata, mem_*, and busy are 0.
  - An in-flight access is aborted with no ack. The RAM write happens only if its edge had already occurred.
- Request latency, with req sampled high at IDLE edge E0:
  - mem_en=1 during E0..E1.
  - ack=1 during E1..E2.
  - Back in IDLE at E2.
  - Next request sampled at E3 at the earliest.
- Throughput: one access per 3 cycles. With both requesters continuously requesting, grants strictly alternate core, host, core, ...
- Ordering: back-to-back accesses from one requester are serialised; a read after a write to the same address returns the new data.
- mem_* outputs are registered (glitch-free); mem_addr/mem_wdata are 0 outside ACCESS.

## Test plan
- Reset, then core write addr 0x05 data 0xA7, then core read 0x05 -> mem_en one cycle each; core_ack 2 cycles after sampled req; core_rdata=0xA7 with ack; host_ack stays 0.
- core_req and host_req high simultaneously from reset, both continuously, distinct addresses -> grant order core, host, core, host; acks every 3 cycles alternating; never coincident.
- host_lock=1 with both requesting for 9 cycles -> three host accesses, zero core accesses. Drop lock -> core granted at the next IDLE.
- Host writes 0x3C to 0xFF (top address), then core reads 0xFF -> core_rdata=0x3C; mem_addr=0xFF in both ACCESS cycles.
- Core write issued, reset_n pulled low during ACCESS -> core_ack never pulses; all outputs 0 immediately; after release, busy=0, owner=1, and the first tie goes to the core.
- core_req dropped the cycle after capture on a write of 0x11 to 0x20 -> write still committed (host read of 0x20 returns 0x11); core_ack still pulses once.

Source files
------------

// File: rtl/lipsi_mem_arbiter_if.sv
// lipsi_mem_arbiter_if
//   Bundles the two requester ports (core, host), the host lock, the
//   single-port RAM port and the arbiter status outputs.
//   Signals:
//     core_req/we/addr/wdata -> arbiter, core_ack/rdata <- arbiter
//     host_req/we/addr/wdata -> arbiter, host_ack/rdata <- arbiter
//     host_lock              -> arbiter, excludes the core while high
//     mem_en/we/addr/wdata   <- arbiter, mem_rdata -> arbiter (1-cycle latency)
//     busy, owner            <- arbiter status
//   Modports: slave = arbiter side, master = requesters/RAM/testbench side.
interface lipsi_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_ack;
  logic [DW-1:0] core_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_lock;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output core_ack, core_rdata, host_ack, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  core_ack, core_rdata, host_ack, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/lipsi_mem_arbiter.sv
// lipsi_mem_arbiter
//   Shares the single-port Lipsi data RAM between the core and a host
//   loader/debug port. Accesses run IDLE -> ACCESS -> RESP (one access per
//   three cycles) with round-robin on ties and a host lock excluding the core.
//   Ports:
//     clk     - rising-edge clock
//     reset_n - asynchronous active-low reset
//     bus     - lipsi_mem_arbiter_if.slave (requesters, RAM port, status)
module lipsi_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  lipsi_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;     // last grant: 0 = core, 1 = host
  logic          acc_we_q, acc_we_d;   // kept past ACCESS to steer rdata in RESP
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          core_elig;
  logic          host_elig;
  logic          win_valid;
  logic          win_host;
  logic          win_we;

  assign core_elig = bus.core_req & ~bus.host_lock;
  assign host_elig = bus.host_req;
  assign win_valid = core_elig | host_elig;
  // On a tie the requester that did not win last time goes next.
  assign win_host  = host_elig & (~core_elig | ~grant_q);
  assign win_we    = win_host ? bus.host_we : bus.core_we;

  // State register (RAM port outputs are registered alongside)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic; requester inputs are only looked at in IDLE
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = ACCESS;
          grant_d     = win_host;
          acc_we_d    = win_we;
          mem_en_d    = 1'b1;
          mem_we_d    = win_we;
          mem_addr_d  = win_host ? bus.host_addr : bus.core_addr;
          if (win_we) begin
            mem_wdata_d = win_host ? bus.host_wdata : bus.core_wdata;
          end
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; RAM read data arrives during RESP, so rdata is passed through
  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.owner      = grant_q;
    bus.core_ack   = (state_q == RESP) & ~grant_q;
    bus.host_ack   = (state_q == RESP) &  grant_q;
    bus.core_rdata = '0;
    bus.host_rdata = '0;
    if (bus.core_ack && !acc_we_q) bus.core_rdata = bus.mem_rdata;
    if (bus.host_ack && !acc_we_q) bus.host_rdata = bus.mem_rdata;
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
module tb_lipsi_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lipsi_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  lipsi_mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port RAM, 1-cycle read latency
  logic [7:0] ram [256];
  logic [7:0] ram_rd;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram_rd = 8'h00;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rd <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rd;

  typedef struct {
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       hreq, hwe;
    logic [7:0] haddr, hwd;
    logic       lock;
    logic       en, we;
    logic [7:0] addr, wd;
    logic       cack;
    logic [7:0] crd;
    logic       hack;
    logic [7:0] hrd;
    logic       busy, owner;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  int cack_cnt, hack_cnt;

  function automatic void V(
    logic creq, logic cwe, logic [7:0] caddr, logic [7:0] cwd,
    logic hreq, logic hwe, logic [7:0] haddr, logic [7:0] hwd, logic lock,
    logic en, logic we, logic [7:0] addr, logic [7:0] wd,
    logic cack, logic [7:0] crd, logic hack, logic [7:0] hrd,
    logic busy, logic owner);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd; v.lock = lock;
    v.en = en; v.we = we; v.addr = addr; v.wd = wd;
    v.cack = cack; v.crd = crd; v.hack = hack; v.hrd = hrd;
    v.busy = busy; v.owner = owner;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr, input logic [7:0] cwd,
                       input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [7:0] hwd,
                       input logic lock);
    bus.core_req = creq; bus.core_we = cwe; bus.core_addr = caddr; bus.core_wdata = cwd;
    bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdata = hwd;
    bus.host_lock = lock;
  endtask

  task automatic chk_all(input string tag, input int idx,
                         input logic en, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                         input logic cack, input logic [7:0] crd, input logic hack, input logic [7:0] hrd,
                         input logic busy, input logic owner);
    chk({tag, ".mem_en"},     idx, 8'(bus.mem_en),   8'(en));
    chk({tag, ".mem_we"},     idx, 8'(bus.mem_we),   8'(we));
    chk({tag, ".mem_addr"},   idx, bus.mem_addr,     addr);
    chk({tag, ".mem_wdata"},  idx, bus.mem_wdata,    wd);
    chk({tag, ".core_ack"},   idx, 8'(bus.core_ack), 8'(cack));
    chk({tag, ".core_rdata"}, idx, bus.core_rdata,   crd);
    chk({tag, ".host_ack"},   idx, 8'(bus.host_ack), 8'(hack));
    chk({tag, ".host_rdata"}, idx, bus.host_rdata,   hrd);
    chk({tag, ".busy"},       idx, 8'(bus.busy),     8'(busy));
    chk({tag, ".owner"},      idx, 8'(bus.owner),    8'(owner));
  endtask

  initial begin
    // Both requesters continuously writing distinct addresses: core, host, core, host
    for (int k = 0; k < 2; k++) begin
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  1,1,8'h10,8'h55, 0,8'h00, 0,8'h00, 1,0);
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  0,0,8'h00,8'h00, 1,8'h00, 0,8'h00, 1,0);
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  1,1,8'h11,8'h66, 0,8'h00, 0,8'h00, 1,1);
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  0,0,8'h00,8'h00, 0,8'h00, 1,8'h00, 1,1);
      V(1,1,8'h10,8'h55, 1,1,8'h11,8'h66, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);
    end
    // Core write 0x05 <- 0xA7, then core read 0x05 (request held through RESP is ignored)
    V(1,1,8'h05,8'hA7, 0,0,8'h00,8'h00, 0,  1,1,8'h05,8'hA7, 0,8'h00, 0,8'h00, 1,0);
    V(1,1,8'h05,8'hA7, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 1,8'h00, 0,8'h00, 1,0);
    V(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
    V(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, 0,  1,0,8'h05,8'h00, 0,8'h00, 0,8'h00, 1,0);
    V(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 1,8'hA7, 0,8'h00, 1,0);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
    // Host reads back its earlier write to 0x11
    V(0,0,8'h00,8'h00, 1,0,8'h11,8'h00, 0,  1,0,8'h11,8'h00, 0,8'h00, 0,8'h00, 1,1);
    V(0,0,8'h00,8'h00, 1,0,8'h11,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 1,8'h66, 1,1);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);
    // Host writes 0x3C to top address 0xFF, core reads it
    V(0,0,8'h00,8'h00, 1,1,8'hFF,8'h3C, 0,  1,1,8'hFF,8'h3C, 0,8'h00, 0,8'h00, 1,1);
    V(0,0,8'h00,8'h00, 1,1,8'hFF,8'h3C, 0,  0,0,8'h00,8'h00, 0,8'h00, 1,8'h00, 1,1);
    V(1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);
    V(1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,  1,0,8'hFF,8'h00, 0,8'h00, 0,8'h00, 1,0);
    V(1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 1,8'h3C, 0,8'h00, 1,0);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
    // Core write 0x11 -> 0x20 with req dropped right after capture; host reads it back
    V(1,1,8'h20,8'h11, 0,0,8'h00,8'h00, 0,  1,1,8'h20,8'h11, 0,8'h00, 0,8'h00, 1,0);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 1,8'h00, 0,8'h00, 1,0);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,0);
    V(0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,  1,0,8'h20,8'h00, 0,8'h00, 0,8'h00, 1,1);
    V(0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 1,8'h11, 1,1);
    V(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,  0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);

    // Reset state
    drive(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven section
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].creq, vq[i].cwe, vq[i].caddr, vq[i].cwd,
            vq[i].hreq, vq[i].hwe, vq[i].haddr, vq[i].hwd, vq[i].lock);
      @(posedge clk);
      #1;
      chk_all("vec", i, vq[i].en, vq[i].we, vq[i].addr, vq[i].wd,
              vq[i].cack, vq[i].crd, vq[i].hack, vq[i].hrd, vq[i].busy, vq[i].owner);
    end

    // Host lock with both requesting for 9 cycles: host only
    @(negedge clk);
    drive(1,0,8'h05,8'h00, 1,0,8'h11,8'h00, 1);
    cack_cnt = 0;
    hack_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (bus.core_ack) cack_cnt++;
      if (bus.host_ack) hack_cnt++;
    end
    chk("lock.core_acks", 0, 8'(cack_cnt), 8'd0);
    chk("lock.host_acks", 0, 8'(hack_cnt), 8'd3);
    chk("lock.busy_at_end", 0, 8'(bus.busy), 8'd0);
    @(negedge clk);
    bus.host_lock = 1'b0;
    @(posedge clk);
    #1;
    chk("unlock.owner", 0, 8'(bus.owner), 8'd0);
    chk("unlock.mem_addr", 0, bus.mem_addr, 8'h05);
    @(posedge clk);
    #1;
    chk("unlock.core_ack", 0, 8'(bus.core_ack), 8'd1);
    chk("unlock.core_rdata", 0, bus.core_rdata, 8'hA7);
    chk("unlock.host_ack", 0, 8'(bus.host_ack), 8'd0);
    @(negedge clk);
    drive(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0);
    @(posedge clk);
    #1;
    chk("unlock.idle_busy", 0, 8'(bus.busy), 8'd0);

    // Asynchronous reset during a core write ACCESS
    @(negedge clk);
    drive(1,1,8'h30,8'h99, 0,0,8'h00,8'h00, 0);
    @(posedge clk);
    #1;
    chk("rstmid.mem_en_before", 0, 8'(bus.mem_en), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rstmid", 0, 0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0,1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rstmid.core_ack_held", c, 8'(bus.core_ack), 8'd0);
    end
    @(negedge clk);
    drive(1,0,8'h30,8'h00, 1,0,8'h11,8'h00, 0);
    reset_n = 1'b1;
    #1;
    chk("rstrel.busy", 0, 8'(bus.busy), 8'd0);
    chk("rstrel.owner", 0, 8'(bus.owner), 8'd1);
    @(posedge clk);
    #1;
    chk("rstrel.tie_owner", 0, 8'(bus.owner), 8'd0);
    chk("rstrel.mem_addr", 0, bus.mem_addr, 8'h30);
    chk("rstrel.mem_we", 0, 8'(bus.mem_we), 8'd0);
    @(posedge clk);
    #1;
    chk("rstrel.core_ack", 0, 8'(bus.core_ack), 8'd1);
    chk("rstrel.aborted_write", 0, bus.core_rdata, 8'h00);
    @(negedge clk);
    drive(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0);
    @(posedge clk);
    #1;
    chk("rstrel.idle", 0, 8'(bus.busy), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
